// File: rtl/imem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder.
//   XLEN        : fetch address width
//   BUS_LEN     : 32-bit words per fetched line
//   BUS_WID     : line width in bits
//   IMEM_LAT_W  : width of the response latency counter (LATENCY <= 15)
package imem_responder_pkg;
    localparam int XLEN       = 32;
    localparam int BUS_LEN    = 2;
    localparam int BUS_WID    = 32 * BUS_LEN;
    localparam int IMEM_LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;
endpackage

// File: rtl/imem_if.sv
// Instruction-fetch bus between fetch unit (master) and memory responder (slave).
//   imem_req   : line request
//   imem_addr  : line byte address
//   imem_rdata : line data, word 0 in [31:0]
//   imem_resp  : one-cycle response strobe
//   imem_err   : response refers to an address outside the RAM
interface imem_if;
    import imem_responder_pkg::*;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [BUS_WID-1:0] imem_rdata;
    logic               imem_resp;
    logic               imem_err;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_resp, imem_err);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_resp, imem_err);
endinterface

// File: rtl/imem_responder_array.sv
// Instruction RAM: MEM_WORDS x 32, one word write port, one line-wide
// synchronous read port (BUS_LEN aligned words).
//   clk     : clock
//   we_i    : word write enable
//   waddr_i : word index to write
//   wdata_i : write data
//   re_i    : capture the addressed line into rdata_o
//   rline_i : line index (word index / BUS_LEN)
//   rdata_o : registered line, held until the next re_i
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic                                   clk,
    input  logic                                   we_i,
    input  logic [$clog2(MEM_WORDS)-1:0]           waddr_i,
    input  logic [31:0]                            wdata_i,
    input  logic                                   re_i,
    input  logic [$clog2(MEM_WORDS/BUS_LEN)-1:0]   rline_i,
    output logic [BUS_WID-1:0]                     rdata_o
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] rbase;

    assign rbase = {rline_i, {$clog2(BUS_LEN){1'b0}}};

    // Read and write share one process with non-blocking updates, so a read
    // of a word written in the same cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            for (int w = 0; w < BUS_LEN; w++) begin
                rdata_o[w*32 +: 32] <= mem[rbase + AW'(w)];
            end
        end
    end
endmodule

// File: rtl/imem_responder.sv
// Slave end of the instruction-fetch bus. Accepts one line request at a time,
// answers LATENCY cycles later with the line snapshotted at accept, or with
// imem_err if the address falls outside the RAM.
//   clk        : clock
//   rst        : synchronous active-low reset
//   bus        : fetch bus, slave side
//   prog_we    : program-port word write enable
//   prog_addr  : program-port word index
//   prog_data  : program-port write data
//   proto_err  : sticky flag, request seen while busy
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    imem_if.slave                        bus,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_WORDS)-1:0] prog_addr,
    input  logic [31:0]                  prog_data,
    output logic                         proto_err
);
    localparam int OFFB = $clog2(4 * BUS_LEN);
    localparam int LW   = $clog2(MEM_WORDS / BUS_LEN);

    imem_state_e           state_q, state_d;
    logic [IMEM_LAT_W-1:0] cnt_q, cnt_d;
    logic                  err_q, perr_q;
    logic                  accept, dec_err, resp;
    logic [XLEN-1:0]       off, line_num, idx;
    logic [BUS_WID-1:0]    line;

    // Decode: line-aligned word index relative to BASE_ADDR. The bound check
    // is done one bit wider so idx+BUS_LEN cannot wrap.
    assign off      = bus.imem_addr - BASE_ADDR;
    assign line_num = off >> OFFB;
    assign idx      = line_num << $clog2(BUS_LEN);
    assign dec_err  = (bus.imem_addr < BASE_ADDR) ||
                      (({1'b0, idx} + 33'(BUS_LEN)) > 33'(MEM_WORDS));

    assign resp   = (state_q == ST_RESP);
    assign accept = bus.imem_req && (state_q != ST_BUSY);

    imem_array #(.MEM_WORDS(MEM_WORDS)) u_array (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .re_i    (accept),
        .rline_i (line_num[LW-1:0]),
        .rdata_o (line)
    );

    // The counter holds the BUSY cycles still to go after the current one,
    // so accept->RESP takes exactly LATENCY edges; LATENCY==1 skips BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = IMEM_LAT_W'(LATENCY - 2);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) err_q <= dec_err;
            if (bus.imem_req && (state_q == ST_BUSY)) perr_q <= 1'b1;
        end
    end

    assign bus.imem_resp  = resp;
    assign bus.imem_err   = resp && err_q;
    assign bus.imem_rdata = (resp && !err_q) ? line : '0;
    assign proto_err      = perr_q;
endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int MW  = 256;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        perr1, perr2;

    always #5 clk = ~clk;

    imem_if b1();
    imem_if b2();

    imem_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(b1), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .proto_err(perr1));

    imem_responder #(.MEM_WORDS(MW), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
        .clk(clk), .rst(rst), .bus(b2), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .proto_err(perr2));

    logic [31:0] mem_m [MW];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [63:0] rdata;
    } vec_t;
    vec_t tv [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: line index = addr/8 words*2; out of range if idx+2 > MW.
    function automatic logic exp_err(input logic [31:0] a);
        longint idx;
        idx = longint'(a >> 3) * 2;
        return (idx + 2) > MW;
    endfunction

    function automatic logic [63:0] exp_line(input logic [31:0] a);
        int idx;
        if (exp_err(a)) return 64'h0;
        idx = int'(a >> 3) * 2;
        return {mem_m[idx+1], mem_m[idx]};
    endfunction

    task automatic prog(input logic [7:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        mem_m[a] = d;
    endtask

    // One request on the LATENCY=2 port; returns latency and response fields,
    // plus whether anything was still asserted the cycle after the response.
    task automatic issue(input logic [31:0] a, input bit wr, input logic [7:0] wa,
                         input logic [31:0] wd, input bit rnd, output int n,
                         output logic e, output logic [63:0] d, output logic nxt);
        b1.imem_req = 1'b1; b1.imem_addr = a;
        prog_we = wr; prog_addr = wa; prog_data = wd;
        tick();
        if (wr) mem_m[wa] = wd;
        b1.imem_req = 1'b0; prog_we = 1'b0;
        n = 1;
        while (!b1.imem_resp && n < 20) begin
            if (rnd) begin
                prog_we = 1'($urandom_range(0, 1));
                prog_addr = 8'($urandom); prog_data = $urandom;
            end
            tick();
            if (prog_we) mem_m[prog_addr] = prog_data;
            prog_we = 1'b0;
            n++;
        end
        e = b1.imem_err; d = b1.imem_rdata;
        tick();
        nxt = b1.imem_resp | b1.imem_err | (|b1.imem_rdata);
    endtask

    task automatic req_model(input string tag, input logic [31:0] a, input bit wr,
                             input logic [7:0] wa, input logic [31:0] wd, input bit rnd);
        logic ee, e, nxt; logic [63:0] el, d; int n;
        ee = exp_err(a); el = exp_line(a);
        issue(a, wr, wa, wd, rnd, n, e, d, nxt);
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        chk({tag, "_err"}, 64'(e), 64'(ee));
        chk({tag, "_data"}, d, el);
        chk({tag, "_pulse"}, 64'(nxt), 64'h0);
    endtask

    // Request held/re-raised on every response cycle, lines 0,8,16.
    task automatic stream(input int which, input int lat);
        logic [31:0] a [3];
        int k, cyc, last;
        logic r, p;
        logic [63:0] d;
        a[0] = 32'h0; a[1] = 32'h8; a[2] = 32'h10;
        k = 0; cyc = 0; last = 0;
        if (which == 0) begin b1.imem_req = 1'b1; b1.imem_addr = a[0]; end
        else begin b2.imem_req = 1'b1; b2.imem_addr = a[0]; end
        while (k < 3 && cyc < 40) begin
            tick(); cyc++;
            r = (which == 0) ? b1.imem_resp : b2.imem_resp;
            d = (which == 0) ? b1.imem_rdata : b2.imem_rdata;
            if (r) begin
                chk("stream_gap", 64'(cyc - last), 64'(lat));
                chk("stream_data", d, exp_line(a[k]));
                last = cyc; k++;
            end
            if (which == 0) begin
                b1.imem_req = r && (k < 3); b1.imem_addr = a[(k < 3) ? k : 0];
            end else begin
                b2.imem_req = r && (k < 3); b2.imem_addr = a[(k < 3) ? k : 0];
            end
        end
        b1.imem_req = 1'b0; b2.imem_req = 1'b0;
        tick();
        p = (which == 0) ? perr1 : perr2;
        chk("stream_count", 64'(k), 64'd3);
        chk("stream_perr", 64'(p), 64'h0);
    endtask

    initial begin
        int n, cnt;
        logic e, nxt;
        logic [63:0] d;
        logic [31:0] ra;

        b1.imem_req = 1'b0; b1.imem_addr = '0;
        b2.imem_req = 1'b0; b2.imem_addr = '0;

        // Reset state
        tick(); tick();
        chk("rst_resp", 64'(b1.imem_resp), 64'h0);
        chk("rst_err", 64'(b1.imem_err), 64'h0);
        chk("rst_rdata", b1.imem_rdata, 64'h0);
        chk("rst_perr", 64'(perr1), 64'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < MW; i++) prog(8'(i), $urandom);
        prog(8'd0, 32'h00000013);
        prog(8'd1, 32'h00100093);
        prog(8'd254, 32'hAAAA0FE0);
        prog(8'd255, 32'h55550FF0);

        // Directed vectors with constant expectations
        tv[0] = '{32'h0,        1'b0, 64'h00100093_00000013};
        tv[1] = '{32'h4,        1'b0, 64'h00100093_00000013};
        tv[2] = '{32'h400,      1'b1, 64'h0};
        tv[3] = '{32'h3FC,      1'b0, 64'h55550FF0_AAAA0FE0};
        tv[4] = '{32'hFFFFFFF8, 1'b1, 64'h0};
        tv[5] = '{32'h3F8,      1'b0, 64'h55550FF0_AAAA0FE0};
        for (int i = 0; i < 6; i++) begin
            issue(tv[i].addr, 1'b0, 8'd0, 32'd0, 1'b0, n, e, d, nxt);
            chk($sformatf("vec%0d_lat", i), 64'(n), 64'(LAT));
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(tv[i].err));
            chk($sformatf("vec%0d_data", i), d, tv[i].rdata);
            chk($sformatf("vec%0d_pulse", i), 64'(nxt), 64'h0);
        end

        // Back-to-back accepts in the response cycle, both latencies
        stream(0, LAT);
        stream(1, 1);

        // Request while busy: ignored, sticky protocol error
        b1.imem_req = 1'b1; b1.imem_addr = 32'h0;
        tick();
        b1.imem_addr = 32'h8;
        tick();
        b1.imem_req = 1'b0;
        chk("busy_resp", 64'(b1.imem_resp), 64'h1);
        chk("busy_data", b1.imem_rdata, exp_line(32'h0));
        chk("busy_perr", 64'(perr1), 64'h1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin tick(); cnt += int'(b1.imem_resp); end
        chk("busy_no_extra", 64'(cnt), 64'h0);
        req_model("after_busy", 32'h10, 1'b0, 8'd0, 32'd0, 1'b0);
        chk("perr_sticky", 64'(perr1), 64'h1);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("perr_cleared", 64'(perr1), 64'h0);

        // Reset while a request is outstanding: response dropped
        b1.imem_req = 1'b1; b1.imem_addr = 32'h0;
        tick();
        b1.imem_req = 1'b0; rst = 1'b0;
        tick();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(); cnt += int'(b1.imem_resp); end
        chk("rst_drop", 64'(cnt), 64'h0);
        req_model("post_rst", 32'h0, 1'b0, 8'd0, 32'd0, 1'b0);

        // Write to the fetched word in the accept cycle: old data returned
        issue(32'h0, 1'b1, 8'd0, 32'hDEADBEEF, 1'b0, n, e, d, nxt);
        chk("rbw_old", d, 64'h00100093_00000013);
        issue(32'h0, 1'b0, 8'd0, 32'd0, 1'b0, n, e, d, nxt);
        chk("rbw_new", d, 64'h00100093_DEADBEEF);

        // Randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 32'h47F));
            req_model("rand", ra, 1'($urandom_range(0, 1)), 8'(ra >> 2), $urandom, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
